// File: rtl/mul_sched_pkg.sv
// Shared constants and types for the multiplier-sharing scheduler.
// The id field is sized for the largest supported requester count (8).
package mul_sched_pkg;
  localparam int OP_W     = 16;
  localparam int P_W      = 33;
  localparam int ID_MAX_W = 3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/mul_rsp_fifo.sv
// Per-requester response FIFO. A push while full is accepted only when a pop
// frees the head in the same cycle. The head reads as zero while empty.
module mul_rsp_fifo
  import mul_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [P_W-1:0]               din,
  output logic [P_W-1:0]               dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [P_W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters,
// with credit-protected per-requester response FIFOs.
module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MUL_LAT   = 6,
  parameter int RSP_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [OP_W*NREQ-1:0]   req_a,
  input  logic [OP_W*NREQ-1:0]   req_b,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  input  logic [P_W-1:0]         mul_p,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [P_W*NREQ-1:0]    rsp_p,
  output logic                   busy
);
  localparam int IDW = id_w(NREQ);
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int IFW = $clog2(MUL_LAT + 2);

  logic [IDW-1:0]               rr_ptr, gnt_id;
  logic                         gnt_any, any_tag;
  logic [NREQ-1:0]              eligible, push, pop, fifo_full, fifo_empty;
  logic [NREQ-1:0][CW-1:0]      credit, fifo_cnt;
  logic [NREQ-1:0][IFW-1:0]     inflight;
  // Stage 0 is loaded with the operands; stage MUL_LAT lines up with mul_p.
  tag_t [MUL_LAT:0]             vld_pipe;
  tag_t                         last;

  always_comb begin
    int idx;
    idx       = 0;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_any && eligible[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      rr_ptr   <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[MUL_LAT-1:0], tag_t'{valid: gnt_any, id: ID_MAX_W'(gnt_id)}};
      if (gnt_any) begin
        mul_a  <= req_a[gnt_id*OP_W +: OP_W];
        mul_b  <= req_b[gnt_id*OP_W +: OP_W];
        rr_ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
      end else begin
        mul_a <= '0;
        mul_b <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) credit[i] <= CW'(RSP_DEPTH);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && !pop[i])      credit[i] <= credit[i] - CW'(1);
        else if (pop[i] && !req_ready[i]) credit[i] <= credit[i] + CW'(1);
      end
    end
  end

  always_comb begin
    any_tag  = 1'b0;
    inflight = '0;
    for (int s = 0; s <= MUL_LAT; s++) begin
      if (vld_pipe[s].valid) begin
        any_tag = 1'b1;
        inflight[vld_pipe[s].id[IDW-1:0]] += IFW'(1);
      end
    end
  end

  assign last = vld_pipe[MUL_LAT];
  assign busy = any_tag | (|rsp_valid);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign eligible[i]  = req_valid[i] & (credit[i] != '0);
    assign push[i]      = last.valid & (last.id == ID_MAX_W'(i));
    assign pop[i]       = rsp_valid[i] & rsp_ready[i];
    assign rsp_valid[i] = ~fifo_empty[i];

    mul_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (mul_p),
      .dout  (rsp_p[i*P_W +: P_W]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (fifo_cnt[i])
    );

    a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
      !(push[i] && fifo_full[i] && !pop[i]));
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
      int'(credit[i]) + int'(inflight[i]) + int'(fifo_cnt[i]) == RSP_DEPTH);
  end
endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched: stimulus predicts grants and products,
// a separate monitor checks response timing and data as FIFOs drain.
module tb_mul_share_sched;
  import mul_sched_pkg::*;

  localparam int NREQ = 4, MUL_LAT = 6, RSP_DEPTH = 2, LAT = MUL_LAT + 2;

  logic                 clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [OP_W*NREQ-1:0] req_a, req_b;
  logic [OP_W-1:0]      mul_a, mul_b;
  logic [P_W-1:0]       mul_p;
  logic [P_W*NREQ-1:0]  rsp_p;
  logic                 busy;

  always #5 clk = ~clk;

  mul_share_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .busy(busy));

  // Behavioural pipelined multiplier: product appears MUL_LAT cycles after operands.
  logic [P_W-1:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= P_W'(mul_a) * P_W'(mul_b);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_p = mpipe[MUL_LAT-1];

  typedef struct { logic [P_W-1:0] p; int due; } exp_t;
  exp_t           q [NREQ][$];
  int             outstanding [NREQ];
  int             rr_m, cyc, total, bad, grants2;
  logic [OP_W-1:0] exp_ma, exp_mb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [OP_W*NREQ-1:0] a,
                      input logic [OP_W*NREQ-1:0] b, input logic [NREQ-1:0] r);
    int win, idx;
    logic any;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = r;
    #1;
    chk("mul_a", mul_a, exp_ma);
    chk("mul_b", mul_b, exp_mb);
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) if (outstanding[i] != 0) any = 1'b1;
    chk("busy", busy, any);
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (rr_m + k) % NREQ;
      if (win < 0 && v[idx] && outstanding[idx] < RSP_DEPTH) win = idx;
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    exp_ma = '0; exp_mb = '0;
    if (win >= 0) begin
      exp_ma = a[win*OP_W +: OP_W];
      exp_mb = b[win*OP_W +: OP_W];
      q[win].push_back('{p: P_W'(exp_ma) * P_W'(exp_mb), due: cyc + LAT});
      outstanding[win]++;
      rr_m = (win + 1) % NREQ;
      if (win == 2) grants2++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    #1;
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_p", rsp_p, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    for (int i = 0; i < NREQ; i++) begin
      q[i].delete();
      outstanding[i] = 0;
    end
    rr_m = 0; exp_ma = '0; exp_mb = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: the DUT's FIFO heads must follow the expected queues exactly.
  initial forever begin
    logic ev;
    exp_t e;
    @(negedge clk); #2;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        ev = 1'b0;
        if (q[i].size() > 0) ev = (q[i][0].due <= cyc);
        chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], ev);
        if (ev) begin
          chk($sformatf("rsp_p[%0d]", i), rsp_p[i*P_W +: P_W], q[i][0].p);
          if (rsp_ready[i]) begin
            e = q[i].pop_front();
            outstanding[i]--;
          end
        end
      end
    end
  end

  function automatic logic [OP_W-1:0] rnd_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return OP_W'(1);
      default: return OP_W'($urandom);
    endcase
  endfunction

  task automatic rnd_ops(output logic [OP_W*NREQ-1:0] a, output logic [OP_W*NREQ-1:0] b);
    for (int i = 0; i < NREQ; i++) begin
      a[i*OP_W +: OP_W] = rnd_op();
      b[i*OP_W +: OP_W] = rnd_op();
    end
  endtask

  initial begin
    logic [OP_W*NREQ-1:0] a, b;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    total = 0; bad = 0; cyc = 0; grants2 = 0;
    do_reset();

    // Single op from requester 1, then let it drain.
    a = '0; b = '0;
    a[1*OP_W +: OP_W] = 16'h1234; b[1*OP_W +: OP_W] = 16'h5678;
    step(4'b0010, a, b, 4'hF);
    repeat (12) step('0, '0, '0, 4'hF);

    // Operand extremes.
    a = '0; b = '0;
    a[0 +: OP_W] = 16'hFFFF;          b[0 +: OP_W] = 16'hFFFF;
    a[2*OP_W +: OP_W] = 16'h0000;     b[2*OP_W +: OP_W] = 16'hABCD;
    a[3*OP_W +: OP_W] = 16'h0001;     b[3*OP_W +: OP_W] = 16'hBEEF;
    step(4'b0001, a, b, 4'hF);
    step(4'b0100, a, b, 4'hF);
    step(4'b1000, a, b, 4'hF);
    repeat (12) step('0, '0, '0, 4'hF);

    // Fairness: everyone requesting, all responses drained.
    repeat (16) begin rnd_ops(a, b); step(4'hF, a, b, 4'hF); end
    repeat (12) step('0, '0, '0, 4'hF);

    // Backpressure on requester 2.
    grants2 = 0;
    repeat (20) begin rnd_ops(a, b); step(4'hF, a, b, 4'b1011); end
    chk("bp_grants_req2", grants2, 2);
    grants2 = 0;
    rnd_ops(a, b); step(4'hF, a, b, 4'hF);
    repeat (12) begin rnd_ops(a, b); step(4'hF, a, b, 4'b1011); end
    chk("bp_regrant_req2", grants2, 1);
    repeat (14) step('0, '0, '0, 4'hF);

    // Reset with three operations in flight.
    rnd_ops(a, b); step(4'b0001, a, b, 4'hF);
    rnd_ops(a, b); step(4'b0010, a, b, 4'hF);
    rnd_ops(a, b); step(4'b1000, a, b, 4'hF);
    do_reset();
    rnd_ops(a, b); step(4'b0001, a, b, 4'hF);
    repeat (12) step('0, '0, '0, 4'hF);

    // Random traffic.
    repeat (10000) begin
      rnd_ops(a, b);
      step(NREQ'($urandom), a, b, NREQ'($urandom | $urandom));
    end
    repeat (20) step('0, '0, '0, 4'hF);
    for (int i = 0; i < NREQ; i++) chk($sformatf("final_left[%0d]", i), q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
